// File: rtl/if_stage_pipe.sv
// if_stage_pipe: MIPS instruction-fetch stage with PC, next-PC select,
// imem req/ready handshake, IF/ID register, stall/flush, stall counter.
// Ports: clk, rst (async active-low); stall, and_z_b, Jmp, branch_adder,
//   jmp_addr, address_on_reg from hazard unit / ID; imem_req, imem_addr,
//   imem_ready, imem_rdata to instruction memory; instruction, pc2id,
//   if_id_valid to ID; misalign pulse; stall_cycles saturating counter.
module if_stage_pipe #(
    parameter int ADDR_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              and_z_b,
    input  logic [1:0]        Jmp,
    input  logic [ADDR_W-1:0] branch_adder,
    input  logic [25:0]       jmp_addr,
    input  logic [ADDR_W-1:0] address_on_reg,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instruction,
    output logic [ADDR_W-1:0] pc2id,
    output logic              if_id_valid,
    output logic              misalign,
    output logic [CNT_W-1:0]  stall_cycles
);

    typedef enum logic {
        BOOT,
        RUN
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] jtgt;
    logic [ADDR_W-1:0] tgt_raw;
    logic [ADDR_W-1:0] tgt;
    logic              is_jr;
    logic              is_j;
    logic              redirect;
    logic              tgt_mis;
    logic              run;

    assign pc_plus4 = pc + ADDR_W'(4);
    assign imem_addr = pc;
    assign run = (state_q == RUN);
    assign imem_req = run;

    // Upper PC bits come from the delay-slot address, as in MIPS J-type.
    if (ADDR_W > 28) begin : g_jwide
        assign jtgt = {pc_plus4[ADDR_W-1:28], jmp_addr, 2'b00};
    end else begin : g_jnarrow
        assign jtgt = {jmp_addr, 2'b00};
    end

    assign is_jr = (Jmp == 2'b10);
    assign is_j = (Jmp == 2'b01);
    assign redirect = is_jr | is_j | and_z_b;

    always_comb begin
        tgt_raw = branch_adder;
        unique case (1'b1)
            is_jr:   tgt_raw = address_on_reg;
            is_j:    tgt_raw = jtgt;
            default: tgt_raw = branch_adder;
        endcase
    end

    assign tgt = {tgt_raw[ADDR_W-1:2], 2'b00};
    assign tgt_mis = |tgt_raw[1:0];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BOOT:    state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc           <= RESET_PC;
            instruction  <= '0;
            pc2id        <= '0;
            if_id_valid  <= 1'b0;
            misalign     <= 1'b0;
            stall_cycles <= '0;
        end else begin
            misalign <= 1'b0;
            if (run) begin
                if (redirect) begin
                    // Fetched word belongs to the wrong path: drop it.
                    pc          <= tgt;
                    if_id_valid <= 1'b0;
                    misalign    <= tgt_mis;
                end else if (stall || !imem_ready) begin
                    if (!stall) begin
                        if_id_valid <= 1'b0;
                    end
                    if (stall_cycles != '1) begin
                        stall_cycles <= stall_cycles + 1'b1;
                    end
                end else begin
                    pc          <= pc_plus4;
                    instruction <= imem_rdata;
                    pc2id       <= pc_plus4;
                    if_id_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_if_stage_pipe.sv
// tb_if_stage_pipe: directed self-checking bench for if_stage_pipe.
// Memory returns {8'hA5, addr[23:0]} unless a fixed word is forced.
module tb_if_stage_pipe;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        and_z_b;
    logic [1:0]  Jmp;
    logic [31:0] branch_adder;
    logic [25:0] jmp_addr;
    logic [31:0] address_on_reg;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] pc2id;
    logic        if_id_valid;
    logic        misalign;
    logic [15:0] stall_cycles;

    logic        use_fixed;
    logic [31:0] fixed_word;

    int errors = 0;
    int checks = 0;

    if_stage_pipe #(
        .ADDR_W(32),
        .RESET_PC(32'h0),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .and_z_b(and_z_b),
        .Jmp(Jmp),
        .branch_adder(branch_adder),
        .jmp_addr(jmp_addr),
        .address_on_reg(address_on_reg),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ready(imem_ready),
        .imem_rdata(imem_rdata),
        .instruction(instruction),
        .pc2id(pc2id),
        .if_id_valid(if_id_valid),
        .misalign(misalign),
        .stall_cycles(stall_cycles)
    );

    assign imem_rdata = use_fixed ? fixed_word
                                  : {8'hA5, imem_addr[23:0]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_if(input string tag,
                          input logic [31:0] addr,
                          input logic [31:0] ins,
                          input logic [31:0] p4,
                          input logic v);
        chk({tag, ".addr"}, imem_addr, addr);
        chk({tag, ".instr"}, instruction, ins);
        chk({tag, ".pc2id"}, pc2id, p4);
        chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, v});
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, ".req"}, {31'd0, imem_req}, 32'd0);
        chk({tag, ".mis"}, {31'd0, misalign}, 32'd0);
        chk({tag, ".cnt"}, {16'd0, stall_cycles}, 32'd0);
        chk_if(tag, 32'h0, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        rst = 1'b0;
        stall = 1'b0;
        and_z_b = 1'b0;
        Jmp = 2'b00;
        branch_adder = '0;
        jmp_addr = '0;
        address_on_reg = '0;
        imem_ready = 1'b1;
        use_fixed = 1'b0;
        fixed_word = '0;
        #1;
        chk_rst("reset");
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("boot.req", {31'd0, imem_req}, 32'd0);

        tick();
        chk("run.req", {31'd0, imem_req}, 32'd1);
        chk_if("run0", 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        chk_if("f0", 32'h4, 32'hA500_0000, 32'h4, 1'b1);
        tick();
        chk_if("f1", 32'h8, 32'hA500_0004, 32'h8, 1'b1);
        tick();
        chk_if("f2", 32'hC, 32'hA500_0008, 32'hC, 1'b1);
        tick();
        chk_if("f3", 32'h10, 32'hA500_000C, 32'h10, 1'b1);
        chk("f3.cnt", {16'd0, stall_cycles}, 32'd0);

        imem_ready = 1'b0;
        tick();
        chk_if("w1", 32'h10, 32'hA500_000C, 32'h10, 1'b0);
        chk("w1.cnt", {16'd0, stall_cycles}, 32'd1);
        tick();
        chk_if("w2", 32'h10, 32'hA500_000C, 32'h10, 1'b0);
        tick();
        chk_if("w3", 32'h10, 32'hA500_000C, 32'h10, 1'b0);
        chk("w3.cnt", {16'd0, stall_cycles}, 32'd3);
        imem_ready = 1'b1;
        tick();
        chk_if("resume", 32'h14, 32'hA500_0010, 32'h14, 1'b1);

        use_fixed = 1'b1;
        fixed_word = 32'h8C01_0004;
        tick();
        chk_if("ld", 32'h18, 32'h8C01_0004, 32'h18, 1'b1);
        use_fixed = 1'b0;
        stall = 1'b1;
        tick();
        chk_if("s1", 32'h18, 32'h8C01_0004, 32'h18, 1'b1);
        tick();
        chk_if("s2", 32'h18, 32'h8C01_0004, 32'h18, 1'b1);
        chk("s2.cnt", {16'd0, stall_cycles}, 32'd5);

        and_z_b = 1'b1;
        branch_adder = 32'h40;
        tick();
        chk_if("br", 32'h40, 32'h8C01_0004, 32'h18, 1'b0);
        chk("br.cnt", {16'd0, stall_cycles}, 32'd5);
        chk("br.mis", {31'd0, misalign}, 32'd0);
        stall = 1'b0;
        and_z_b = 1'b0;
        Jmp = 2'b01;
        jmp_addr = 26'h000_0100;
        tick();
        chk("j.addr", imem_addr, 32'h400);
        chk("j.valid", {31'd0, if_id_valid}, 32'd0);

        Jmp = 2'b10;
        address_on_reg = 32'h203;
        and_z_b = 1'b1;
        branch_adder = 32'h80;
        tick();
        chk("jr.addr", imem_addr, 32'h200);
        chk("jr.mis", {31'd0, misalign}, 32'd1);
        Jmp = 2'b00;
        and_z_b = 1'b0;
        tick();
        chk_if("jr.f", 32'h204, 32'hA500_0200, 32'h204, 1'b1);
        chk("jr.mis0", {31'd0, misalign}, 32'd0);
        chk("jr.cnt", {16'd0, stall_cycles}, 32'd5);

        Jmp = 2'b10;
        address_on_reg = 32'hFFFF_FFFC;
        tick();
        chk("top.addr", imem_addr, 32'hFFFF_FFFC);
        Jmp = 2'b00;
        tick();
        chk_if("wrap", 32'h0, 32'hA5FF_FFFC, 32'h0, 1'b1);

        Jmp = 2'b11;
        tick();
        chk_if("rsvd", 32'h4, 32'hA500_0000, 32'h4, 1'b1);
        Jmp = 2'b00;

        and_z_b = 1'b1;
        branch_adder = 32'h100;
        tick();
        chk("b100.addr", imem_addr, 32'h100);
        and_z_b = 1'b0;
        imem_ready = 1'b0;
        tick();
        chk("mw.cnt", {16'd0, stall_cycles}, 32'd6);
        #2;
        rst = 1'b0;
        #1;
        chk_rst("arst");
        imem_ready = 1'b1;
        tick();
        chk_rst("arst.hold");
        rst = 1'b1;
        #1;
        chk("boot2.req", {31'd0, imem_req}, 32'd0);
        tick();
        chk("run2.req", {31'd0, imem_req}, 32'd1);
        chk("run2.addr", imem_addr, 32'h0);
        tick();
        chk_if("f0b", 32'h4, 32'hA500_0000, 32'h4, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
